writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all register-file state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port vale, input, 64 bits: execute-stage result valE.
REQ-005 The block SHALL have port valm, input, 64 bits: memory-stage read data valM.
REQ-006 The block SHALL have port condition_cnd, input, 1 bit: condition flag Cnd from execute.
REQ-007 The block SHALL have port ra, input, 4 bits: rA register specifier.
REQ-008 The block SHALL have port rb, input, 4 bits: rB register specifier.
REQ-009 The block SHALL have port icode, input, 4 bits: Y86-64 instruction code.
REQ-010 The block SHALL have ports register0 .. register14, output, 64 bits each: current contents of the 15 Y86-64 program registers (register4 = %rsp); all driven directly from state, with no combinational path from inputs.

Function
REQ-011 The block SHALL derive destination dstE and source data valE as follows: icode 2 (cmovXX) -> dstE = rb only if condition_cnd = 1, else 0xF; icode 3 (irmovq) and 6 (OPq) -> dstE = rb; icode 8 (call), 9 (ret), A (pushq), B (popq) -> dstE = 4; all other icodes -> dstE = 0xF.
REQ-012 The block SHALL derive dstM: icode 5 (mrmovq) and B (popq) -> dstM = ra; all other icodes -> dstM = 0xF.
REQ-013 On each rising clock edge with reset_n = 1, the block SHALL write vale into register[dstE] when dstE != 0xF.
REQ-014 On the same edge, the block SHALL write valm into register[dstM] when dstM != 0xF.
REQ-015 Specifier 0xF SHALL mean "no register"; no register SHALL be modified for it.
REQ-016 When dstE = dstM (for example, popq %rsp), the valm write SHALL take priority, so that register[dstM] = valm.
REQ-017 condition_cnd SHALL be ignored for every icode except 2.
REQ-018 Registers not addressed by dstE or dstM SHALL hold their value.
REQ-019 Write latency SHALL be one edge: the new value is visible on the register outputs immediately after the rising edge on which it is captured.
REQ-020 icode values 0, 1, 4, 7 and C-F SHALL perform no write.

Reset
REQ-021 While reset_n = 0, register0..register14 SHALL all be 64'd0, asynchronously, regardless of clock.
REQ-022 Reset asserted mid-operation SHALL override any pending write.
REQ-023 The first write after reset_n rises SHALL occur on the next rising clock edge.

Verification
REQ-024 OPq: icode=6, rb=8, ra=3, vale=45, valm=33, condition_cnd=0, one rising edge -> register8=45; all other registers unchanged (0 after reset).
REQ-025 cmovXX, taken: icode=2, rb=4, ra=1, vale=100, condition_cnd=1, edge -> register4=100. Not taken: same with condition_cnd=0 -> register4 unchanged.
REQ-026 ret: icode=9, ra=7, rb=11, vale=20, valm=10, edge -> register4=20; register7 and register11 unchanged.
REQ-027 popq: icode=B, ra=3, vale=64, valm=7, edge -> register4=64 and register3=7. popq %rsp: ra=4, vale=64, valm=7 -> register4=7.
REQ-028 No-write cases: mrmovq with ra=0xF, irmovq with rb=0xF, and icode=4 (rmmovq), each with vale=valm=5 -> no register changes.
REQ-029 Reset: write nonzero values into several registers, then drive reset_n=0 between clock edges -> all outputs read 0 immediately; with reset_n held low, a clock edge with icode=6, rb=2 -> register2 stays 0.

Source files
------------

// File: rtl/writeback.sv
// rtl/writeback.sv - Y86-64 writeback stage holding the 15 program registers.
// Decodes dstE/dstM from icode and commits valE/valM on the rising clock edge.
module writeback (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [63:0] vale,
   input  logic [63:0] valm,
   input  logic        condition_cnd,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  icode,
   output logic [63:0] register0,
   output logic [63:0] register1,
   output logic [63:0] register2,
   output logic [63:0] register3,
   output logic [63:0] register4,
   output logic [63:0] register5,
   output logic [63:0] register6,
   output logic [63:0] register7,
   output logic [63:0] register8,
   output logic [63:0] register9,
   output logic [63:0] register10,
   output logic [63:0] register11,
   output logic [63:0] register12,
   output logic [63:0] register13,
   output logic [63:0] register14
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   logic [3:0]  dst_e;
   logic [3:0]  dst_m;
   logic [63:0] regs [15];

   always_comb begin
      dst_e = RNONE;
      case (icode)
         4'h2: if (condition_cnd) dst_e = rb;
         4'h3, 4'h6: dst_e = rb;
         4'h8, 4'h9, 4'hA, 4'hB: dst_e = RSP;
         default: dst_e = RNONE;
      endcase
   end

   always_comb begin
      dst_m = RNONE;
      case (icode)
         4'h5, 4'hB: dst_m = ra;
         default: dst_m = RNONE;
      endcase
   end

   // valM is checked first so it wins when both ports hit the same register (popq %rsp).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (dst_m == 4'(i))
               regs[i] <= valm;
            else if (dst_e == 4'(i))
               regs[i] <= vale;
         end
      end
   end

   assign register0  = regs[0];
   assign register1  = regs[1];
   assign register2  = regs[2];
   assign register3  = regs[3];
   assign register4  = regs[4];
   assign register5  = regs[5];
   assign register6  = regs[6];
   assign register7  = regs[7];
   assign register8  = regs[8];
   assign register9  = regs[9];
   assign register10 = regs[10];
   assign register11 = regs[11];
   assign register12 = regs[12];
   assign register13 = regs[13];
   assign register14 = regs[14];

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - table-driven scoreboard bench for the writeback register file.
module tb_writeback;

   typedef logic [14:0][63:0] snap_t;

   typedef struct {
      string       name;
      logic [3:0]  icode;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        cnd;
      logic [63:0] vale;
      logic [63:0] valm;
      logic [3:0]  wi0;
      logic [63:0] wv0;
      logic [3:0]  wi1;
      logic [63:0] wv1;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] vale = '0;
   logic [63:0] valm = '0;
   logic        condition_cnd = 1'b0;
   logic [3:0]  ra = '0;
   logic [3:0]  rb = '0;
   logic [3:0]  icode = '0;
   logic [63:0] register0, register1, register2, register3, register4;
   logic [63:0] register5, register6, register7, register8, register9;
   logic [63:0] register10, register11, register12, register13, register14;

   snap_t act_s;
   snap_t exp_s;
   snap_t sb_q[$];
   vec_t  vecs[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   writeback dut (
      .clock(clock), .reset_n(reset_n), .vale(vale), .valm(valm),
      .condition_cnd(condition_cnd), .ra(ra), .rb(rb), .icode(icode),
      .register0(register0), .register1(register1), .register2(register2),
      .register3(register3), .register4(register4), .register5(register5),
      .register6(register6), .register7(register7), .register8(register8),
      .register9(register9), .register10(register10), .register11(register11),
      .register12(register12), .register13(register13), .register14(register14)
   );

   assign act_s = {register14, register13, register12, register11, register10,
                   register9, register8, register7, register6, register5,
                   register4, register3, register2, register1, register0};

   always #5 clock = ~clock;

   function automatic vec_t mk(string n, logic [3:0] ic, logic [3:0] a, logic [3:0] b,
                               logic c, logic [63:0] e, logic [63:0] m,
                               logic [3:0] i0, logic [63:0] v0,
                               logic [3:0] i1, logic [63:0] v1);
      vec_t v;
      v.name = n; v.icode = ic; v.ra = a; v.rb = b; v.cnd = c;
      v.vale = e; v.valm = m; v.wi0 = i0; v.wv0 = v0; v.wi1 = i1; v.wv1 = v1;
      return v;
   endfunction

   task automatic drive(logic [3:0] ic, logic [3:0] a, logic [3:0] b, logic c,
                        logic [63:0] e, logic [63:0] m);
      icode = ic; ra = a; rb = b; condition_cnd = c; vale = e; valm = m;
   endtask

   task automatic pop_check(string name);
      snap_t exp;
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s scoreboard empty actual=none required=snapshot", name);
         return;
      end
      exp = sb_q.pop_front();
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (act_s[i] !== exp[i]) begin
            n_bad++;
            $display("FAIL %s register%0d actual=%h required=%h", name, i, act_s[i], exp[i]);
         end
      end
   endtask

   initial begin
      vecs.push_back(mk("opq_r8",        4'h6, 4'h3, 4'h8, 1'b0, 64'd45,  64'd33,  4'h8, 64'd45,  4'hF, 64'd0));
      vecs.push_back(mk("cmov_taken",    4'h2, 4'h1, 4'h4, 1'b1, 64'd100, 64'd0,   4'h4, 64'd100, 4'hF, 64'd0));
      vecs.push_back(mk("cmov_not",      4'h2, 4'h1, 4'h4, 1'b0, 64'd200, 64'd0,   4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("ret",           4'h9, 4'h7, 4'hB, 1'b0, 64'd20,  64'd10,  4'h4, 64'd20,  4'hF, 64'd0));
      vecs.push_back(mk("popq",          4'hB, 4'h3, 4'hF, 1'b0, 64'd64,  64'd7,   4'h4, 64'd64,  4'h3, 64'd7));
      vecs.push_back(mk("popq_rsp",      4'hB, 4'h4, 4'hF, 1'b0, 64'd64,  64'd7,   4'h4, 64'd7,   4'hF, 64'd0));
      vecs.push_back(mk("mrmov_raF",     4'h5, 4'hF, 4'h2, 1'b0, 64'd5,   64'd5,   4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("irmov_rbF",     4'h3, 4'h2, 4'hF, 1'b0, 64'd5,   64'd5,   4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("rmmov",         4'h4, 4'h1, 4'h2, 1'b0, 64'd5,   64'd5,   4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("irmov_r14",     4'h3, 4'hF, 4'hE, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd1, 4'hE, 64'h1234_5678_9ABC_DEF0, 4'hF, 64'd0));
      vecs.push_back(mk("mrmov_r0",      4'h5, 4'h0, 4'h6, 1'b1, 64'd3,   64'hDEAD_BEEF, 4'h0, 64'hDEAD_BEEF, 4'hF, 64'd0));
      vecs.push_back(mk("opq_cnd_ign",   4'h6, 4'h1, 4'h5, 1'b1, 64'd9,   64'd8,   4'h5, 64'd9,   4'hF, 64'd0));
      vecs.push_back(mk("halt",          4'h0, 4'h1, 4'h2, 1'b1, 64'd77,  64'd78,  4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("nop",           4'h1, 4'h1, 4'h2, 1'b0, 64'd77,  64'd78,  4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("jxx",           4'h7, 4'h1, 4'h2, 1'b1, 64'd77,  64'd78,  4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("icode_c",       4'hC, 4'h1, 4'h2, 1'b0, 64'd77,  64'd78,  4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("icode_f",       4'hF, 4'h1, 4'h2, 1'b1, 64'd77,  64'd78,  4'hF, 64'd0,   4'hF, 64'd0));
      vecs.push_back(mk("call",          4'h8, 4'h1, 4'h2, 1'b0, 64'h80,  64'd78,  4'h4, 64'h80,  4'hF, 64'd0));
      vecs.push_back(mk("pushq",         4'hA, 4'h1, 4'h2, 1'b0, 64'h78,  64'd66,  4'h4, 64'h78,  4'hF, 64'd0));
      vecs.push_back(mk("mrmov_r9",      4'h5, 4'h9, 4'h9, 1'b1, 64'h11,  64'h55,  4'h9, 64'h55,  4'hF, 64'd0));
      vecs.push_back(mk("opq_r1",        4'h6, 4'h1, 4'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 64'd0));

      // Reset held across a clock edge with a write presented.
      drive(4'h6, 4'h3, 4'h8, 1'b0, 64'd45, 64'd0);
      sb_q.push_back('0);
      @(posedge clock); #1;
      pop_check("reset_hold");

      @(negedge clock);
      reset_n = 1'b1;
      exp_s = '0;
      foreach (vecs[k]) begin
         if (k != 0) @(negedge clock);
         drive(vecs[k].icode, vecs[k].ra, vecs[k].rb, vecs[k].cnd, vecs[k].vale, vecs[k].valm);
         if (vecs[k].wi0 != 4'hF) exp_s[vecs[k].wi0] = vecs[k].wv0;
         if (vecs[k].wi1 != 4'hF) exp_s[vecs[k].wi1] = vecs[k].wv1;
         sb_q.push_back(exp_s);
         @(posedge clock); #1;
         pop_check(vecs[k].name);
      end

      // Asynchronous reset between edges clears everything without a clock.
      @(negedge clock); #2;
      reset_n = 1'b0;
      #1;
      sb_q.push_back('0);
      pop_check("async_reset");

      drive(4'h6, 4'h1, 4'h2, 1'b0, 64'd99, 64'd0);
      sb_q.push_back('0);
      @(posedge clock); #1;
      pop_check("reset_blocks_write");

      // First write after release lands on the very next edge.
      @(negedge clock);
      reset_n = 1'b1;
      exp_s = '0;
      exp_s[2] = 64'd99;
      sb_q.push_back(exp_s);
      @(posedge clock); #1;
      pop_check("first_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
